// File: rtl/lsu.sv
// lsu: load/store unit bridging the pipeline memory stage to a req/ack word bus.
// A three-state FSM (IDLE, REQ, DONE) latches the access when it leaves IDLE,
// holds mreq until mack, and aligns and extends load data into readdata.
// Optional feature: define LSU_MISALIGN_TRAP_EN to add the misalign output and
// suppress misaligned half/word accesses instead of issuing them.
module lsu (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        memread,
    input  logic        memwrite,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] storedata,
    output logic [31:0] readdata,
    output logic        stall,
    output logic        mreq,
    output logic        mwe,
    output logic [31:0] maddr,
    output logic [31:0] mwdata,
    output logic [3:0]  mbe,
    input  logic [31:0] mrdata,
    input  logic        mack
`ifdef LSU_MISALIGN_TRAP_EN
    ,
    output logic        misalign
`endif
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t     state;
    logic [2:0] f3_q;
    logic [1:0] lo_q;
    logic       req;

    assign req = memread | memwrite;

    // funct3[1:0]: 00 byte, 01 half, anything else is a word access
    function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] lo);
        case (f3[1:0])
            2'b00:   byte_en = 4'b0001 << lo;
            2'b01:   byte_en = 4'b0011 << {lo[1], 1'b0};
            default: byte_en = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] sd);
        case (f3[1:0])
            2'b00:   store_lanes = {4{sd[7:0]}};
            2'b01:   store_lanes = {2{sd[15:0]}};
            default: store_lanes = sd;
        endcase
    endfunction

    // funct3[2] selects zero extension (LBU/LHU)
    function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] lo,
                                             input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        case (lo)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = lo[1] ? w[31:16] : w[15:0];
        case (f3[1:0])
            2'b00:   load_ext = f3[2] ? {24'b0, b} : {{24{b[7]}}, b};
            2'b01:   load_ext = f3[2] ? {16'b0, h} : {{16{h[15]}}, h};
            default: load_ext = w;
        endcase
    endfunction

`ifdef LSU_MISALIGN_TRAP_EN
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lo);
        case (f3[1:0])
            2'b00:   is_misaligned = 1'b0;
            2'b01:   is_misaligned = lo[0];
            default: is_misaligned = (lo != 2'b00);
        endcase
    endfunction
`endif

    // Stall is forced low during reset so a held request cannot freeze the pipe
    assign stall = rst_n & (((state == IDLE) & req) | (state == REQ));

    // Access FSM: latch the request, run the bus handshake, capture load data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            mreq     <= 1'b0;
            mwe      <= 1'b0;
            maddr    <= 32'b0;
            mwdata   <= 32'b0;
            mbe      <= 4'b0;
            readdata <= 32'b0;
            f3_q     <= 3'b0;
            lo_q     <= 2'b0;
`ifdef LSU_MISALIGN_TRAP_EN
            misalign <= 1'b0;
`endif
        end else begin
`ifdef LSU_MISALIGN_TRAP_EN
            misalign <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (req) begin
                        f3_q   <= funct3;
                        lo_q   <= addr[1:0];
                        mwe    <= memwrite;
                        maddr  <= {addr[31:2], 2'b00};
                        mwdata <= store_lanes(funct3, storedata);
                        mbe    <= memwrite ? byte_en(funct3, addr[1:0]) : 4'b1111;
`ifdef LSU_MISALIGN_TRAP_EN
                        if (is_misaligned(funct3, addr[1:0])) begin
                            state    <= DONE;
                            misalign <= 1'b1;
                        end else begin
                            state <= REQ;
                            mreq  <= 1'b1;
                        end
`else
                        state <= REQ;
                        mreq  <= 1'b1;
`endif
                    end
                end
                REQ: begin
                    if (mack) begin
                        state <= DONE;
                        mreq  <= 1'b0;
                        if (!mwe) begin
                            readdata <= load_ext(f3_q, lo_q, mrdata);
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    mreq  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// tb_lsu: randomized self-checking bench for the lsu with a behavioural model.
module tb_lsu;

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        memread;
    logic        memwrite;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] storedata;
    logic [31:0] readdata;
    logic        stall;
    logic        mreq;
    logic        mwe;
    logic [31:0] maddr;
    logic [31:0] mwdata;
    logic [3:0]  mbe;
    logic [31:0] mrdata;
    logic        mack;
`ifdef LSU_MISALIGN_TRAP_EN
    logic        misalign;
`endif

    int pass_cnt = 0;
    int total    = 0;
    logic [31:0] exp_rd;

    lsu dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .memread   (memread),
        .memwrite  (memwrite),
        .funct3    (funct3),
        .addr      (addr),
        .storedata (storedata),
        .readdata  (readdata),
        .stall     (stall),
        .mreq      (mreq),
        .mwe       (mwe),
        .maddr     (maddr),
        .mwdata    (mwdata),
        .mbe       (mbe),
        .mrdata    (mrdata),
        .mack      (mack)
`ifdef LSU_MISALIGN_TRAP_EN
        ,
        .misalign  (misalign)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: plain shifts and masks of the access rules
    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] w);
        logic [31:0] v;
        int unsigned sz;
        sz = f3 % 4;
        if (sz == 0) begin
            v = (w >> (8 * (a % 4))) & 32'hFF;
            if (f3 == 3'd0 && v >= 32'd128) v = v + 32'hFFFFFF00;
        end else if (sz == 1) begin
            v = (w >> (16 * ((a / 2) % 2))) & 32'hFFFF;
            if (f3 == 3'd1 && v >= 32'd32768) v = v + 32'hFFFF0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    function automatic logic [3:0] ref_mbe(input logic [2:0] f3, input logic [31:0] a);
        int unsigned sz;
        sz = f3 % 4;
        if (sz == 0) return 4'(1 << (a % 4));
        if (sz == 1) return 4'(3 << (2 * ((a / 2) % 2)));
        return 4'hF;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] sd);
        int unsigned sz;
        sz = f3 % 4;
        if (sz == 0) return (sd & 32'hFF) * 32'h01010101;
        if (sz == 1) return (sd & 32'hFFFF) * 32'h00010001;
        return sd;
    endfunction

    function automatic logic [31:0] gen_addr(input logic [2:0] f3);
        logic [31:0] a;
        a = $urandom;
        if (TRAP) begin
            if (f3 % 4 == 1) a = a & ~32'd1;
            else if (f3 % 4 != 0) a = a & ~32'd3;
        end
        return a;
    endfunction

    // Drives one access with mack in cycle d (d>=1); returns observations only
    task automatic access(input bit wr, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] sd, input logic [31:0] rd, input int d,
                          output int sc, output int mc,
                          output logic [31:0] o_maddr, output logic [31:0] o_mwdata,
                          output logic [3:0] o_mbe, output logic o_mwe,
                          output logic [31:0] o_rd, output logic o_dstall,
                          output logic o_unstable);
        sc = 0;
        mc = 0;
        o_unstable = 1'b0;
        o_maddr = 32'b0;
        o_mwdata = 32'b0;
        o_mbe = 4'b0;
        o_mwe = 1'b0;
        o_rd = 32'b0;
        o_dstall = 1'b0;
        memread   = !wr;
        memwrite  = wr;
        funct3    = f3;
        addr      = a;
        storedata = sd;
        for (int c = 0; c <= d + 2; c++) begin
            if (c == 1) begin
                addr      = $urandom;
                storedata = $urandom;
                funct3    = 3'($urandom);
            end
            if (c == d + 2) begin
                memread  = 1'b0;
                memwrite = 1'b0;
            end
            mack   = (c == d);
            mrdata = (c == d) ? rd : $urandom;
            @(negedge clk);
            if (stall) sc++;
            if (mreq) mc++;
            if (c == 1) begin
                o_maddr  = maddr;
                o_mwdata = mwdata;
                o_mbe    = mbe;
                o_mwe    = mwe;
            end
            if (mreq && c > 1 && mwe !== o_mwe) o_unstable = 1'b1;
            if (c == d + 1) begin
                o_rd     = readdata;
                o_dstall = stall;
            end
            @(posedge clk);
            #1;
        end
        mack = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        memread = 1'b1;
        memwrite = 1'b0;
        funct3 = 3'b010;
        addr = 32'h0000_0100;
        storedata = 32'b0;
        mrdata = 32'b0;
        mack = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if (stall !== 1'b0) $display("FAIL reset_stall got %0b want 0", stall); else pass_cnt++;
        total++; if (mreq !== 1'b0) $display("FAIL reset_mreq got %0b want 0", mreq); else pass_cnt++;
        total++; if (mwe !== 1'b0) $display("FAIL reset_mwe got %0b want 0", mwe); else pass_cnt++;
        total++; if (readdata !== 32'b0) $display("FAIL reset_readdata got %h want 0", readdata); else pass_cnt++;
        total++; if (maddr !== 32'b0) $display("FAIL reset_maddr got %h want 0", maddr); else pass_cnt++;
        total++; if (mwdata !== 32'b0) $display("FAIL reset_mwdata got %h want 0", mwdata); else pass_cnt++;
        total++; if (mbe !== 4'b0) $display("FAIL reset_mbe got %b want 0000", mbe); else pass_cnt++;
        memread = 1'b0;
        mack = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_rd = 32'b0;
    endtask

    task automatic test_lw();
        int sc, mc;
        logic [31:0] o_maddr, o_mwdata, o_rd;
        logic [3:0] o_mbe;
        logic o_mwe, o_dstall, o_unst;
        access(1'b0, 3'b010, 32'h100, 32'h1234_5678, 32'hDEADBEEF, 3,
               sc, mc, o_maddr, o_mwdata, o_mbe, o_mwe, o_rd, o_dstall, o_unst);
        exp_rd = 32'hDEADBEEF;
        total++; if (o_maddr !== 32'h100) $display("FAIL lw_maddr got %h want 00000100", o_maddr); else pass_cnt++;
        total++; if (o_mbe !== 4'b1111) $display("FAIL lw_mbe got %b want 1111", o_mbe); else pass_cnt++;
        total++; if (o_mwe !== 1'b0) $display("FAIL lw_mwe got %0b want 0", o_mwe); else pass_cnt++;
        total++; if (sc !== 4) $display("FAIL lw_stall_cycles got %0d want 4", sc); else pass_cnt++;
        total++; if (mc !== 3) $display("FAIL lw_mreq_cycles got %0d want 3", mc); else pass_cnt++;
        total++; if (o_rd !== 32'hDEADBEEF) $display("FAIL lw_readdata got %h want deadbeef", o_rd); else pass_cnt++;
    endtask

    task automatic test_lb_lbu();
        int sc, mc;
        logic [31:0] o_maddr, o_mwdata, o_rd;
        logic [3:0] o_mbe;
        logic o_mwe, o_dstall, o_unst;
        access(1'b0, 3'b000, 32'h103, 32'h0, 32'h80112233, 1,
               sc, mc, o_maddr, o_mwdata, o_mbe, o_mwe, o_rd, o_dstall, o_unst);
        total++; if (o_rd !== 32'hFFFFFF80) $display("FAIL lb_readdata got %h want ffffff80", o_rd); else pass_cnt++;
        total++; if (sc !== 2) $display("FAIL lb_min_latency_stall got %0d want 2", sc); else pass_cnt++;
        total++; if (o_dstall !== 1'b0) $display("FAIL lb_done_stall got %0b want 0", o_dstall); else pass_cnt++;
        access(1'b0, 3'b100, 32'h103, 32'h0, 32'h80112233, 1,
               sc, mc, o_maddr, o_mwdata, o_mbe, o_mwe, o_rd, o_dstall, o_unst);
        exp_rd = 32'h00000080;
        total++; if (o_rd !== 32'h00000080) $display("FAIL lbu_readdata got %h want 00000080", o_rd); else pass_cnt++;
    endtask

    task automatic test_sh();
        int sc, mc;
        logic [31:0] o_maddr, o_mwdata, o_rd;
        logic [3:0] o_mbe;
        logic o_mwe, o_dstall, o_unst;
        access(1'b1, 3'b001, 32'h202, 32'h0000ABCD, 32'h5555_AAAA, 2,
               sc, mc, o_maddr, o_mwdata, o_mbe, o_mwe, o_rd, o_dstall, o_unst);
        total++; if (o_mwe !== 1'b1) $display("FAIL sh_mwe got %0b want 1", o_mwe); else pass_cnt++;
        total++; if (o_maddr !== 32'h200) $display("FAIL sh_maddr got %h want 00000200", o_maddr); else pass_cnt++;
        total++; if (o_mbe !== 4'b1100) $display("FAIL sh_mbe got %b want 1100", o_mbe); else pass_cnt++;
        total++; if (o_mwdata !== 32'hABCDABCD) $display("FAIL sh_mwdata got %h want abcdabcd", o_mwdata); else pass_cnt++;
        total++; if (o_rd !== exp_rd) $display("FAIL sh_readdata_hold got %h want %h", o_rd, exp_rd); else pass_cnt++;
        total++; if (o_unst !== 1'b0) $display("FAIL sh_mwe_stable got %0b want 0", o_unst); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        memread = 1'b1;
        memwrite = 1'b0;
        funct3 = 3'b010;
        addr = 32'h300;
        mack = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        total++; if (mreq !== 1'b1) $display("FAIL midrst_pre_mreq got %0b want 1", mreq); else pass_cnt++;
        #1;
        rst_n = 1'b0;
        #1;
        total++; if (mreq !== 1'b0) $display("FAIL midrst_mreq got %0b want 0", mreq); else pass_cnt++;
        total++; if (stall !== 1'b0) $display("FAIL midrst_stall got %0b want 0", stall); else pass_cnt++;
        total++; if (maddr !== 32'b0) $display("FAIL midrst_maddr got %h want 0", maddr); else pass_cnt++;
        total++; if (readdata !== 32'b0) $display("FAIL midrst_readdata got %h want 0", readdata); else pass_cnt++;
        exp_rd = 32'b0;
        memread = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        mack = 1'b1;
        mrdata = $urandom;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            total++; if (mreq !== 1'b0) $display("FAIL stray_mack_mreq cyc %0d got %0b want 0", i, mreq); else pass_cnt++;
            total++; if (stall !== 1'b0) $display("FAIL stray_mack_stall cyc %0d got %0b want 0", i, stall); else pass_cnt++;
            total++; if (readdata !== exp_rd) $display("FAIL stray_mack_readdata cyc %0d got %h want %h", i, readdata, exp_rd); else pass_cnt++;
            @(posedge clk);
            #1;
        end
        mack = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [2:0] f3;
        logic [31:0] a;
        logic [2:0] loads [5];
        loads = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        mack = 1'b1;
        memwrite = 1'b0;
        f3 = 3'd2;
        a = 32'b0;
        for (int c = 0; c < 9; c++) begin
            if (c % 3 == 0) begin
                f3 = loads[$urandom_range(0, 4)];
                a = gen_addr(f3);
                memread = 1'b1;
                funct3 = f3;
                addr = a;
            end
            mrdata = $urandom;
            if (c % 3 == 1) exp_rd = ref_load(f3, a, mrdata);
            @(negedge clk);
            total++; if (stall !== (c % 3 != 2)) $display("FAIL b2b_stall cyc %0d got %0b want %0b", c, stall, (c % 3 != 2)); else pass_cnt++;
            total++; if (mreq !== (c % 3 == 1)) $display("FAIL b2b_mreq cyc %0d got %0b want %0b", c, mreq, (c % 3 == 1)); else pass_cnt++;
            if (c % 3 == 2) begin
                total++; if (readdata !== exp_rd) $display("FAIL b2b_readdata cyc %0d got %h want %h", c, readdata, exp_rd); else pass_cnt++;
            end
            @(posedge clk);
            #1;
        end
        memread = 1'b0;
        mack = 1'b0;
        @(negedge clk);
        total++; if (mreq !== 1'b0) $display("FAIL b2b_tail_mreq got %0b want 0", mreq); else pass_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        int sc, mc, d;
        bit wr;
        logic [2:0] f3;
        logic [31:0] a, sd, rd;
        logic [31:0] o_maddr, o_mwdata, o_rd;
        logic [3:0] o_mbe;
        logic o_mwe, o_dstall, o_unst;
        for (int n = 0; n < 40; n++) begin
            mack = 1'($urandom);
            mrdata = $urandom;
            @(negedge clk);
            total++; if (mreq !== 1'b0) $display("FAIL rnd_idle_mreq n=%0d got %0b want 0", n, mreq); else pass_cnt++;
            @(posedge clk);
            #1;
            wr = 1'($urandom);
            f3 = 3'($urandom);
            a  = gen_addr(f3);
            sd = $urandom;
            rd = $urandom;
            d  = $urandom_range(1, 4);
            access(wr, f3, a, sd, rd, d,
                   sc, mc, o_maddr, o_mwdata, o_mbe, o_mwe, o_rd, o_dstall, o_unst);
            if (!wr) exp_rd = ref_load(f3, a, rd);
            total++; if (o_maddr !== (a & ~32'd3)) $display("FAIL rnd_maddr n=%0d got %h want %h", n, o_maddr, a & ~32'd3); else pass_cnt++;
            total++; if (o_mwe !== wr) $display("FAIL rnd_mwe n=%0d got %0b want %0b", n, o_mwe, wr); else pass_cnt++;
            total++; if (o_mbe !== (wr ? ref_mbe(f3, a) : 4'hF)) $display("FAIL rnd_mbe n=%0d f3=%0d a=%h got %b want %b", n, f3, a, o_mbe, wr ? ref_mbe(f3, a) : 4'hF); else pass_cnt++;
            if (wr) begin
                total++; if (o_mwdata !== ref_wdata(f3, sd)) $display("FAIL rnd_mwdata n=%0d got %h want %h", n, o_mwdata, ref_wdata(f3, sd)); else pass_cnt++;
            end
            total++; if (o_rd !== exp_rd) $display("FAIL rnd_readdata n=%0d f3=%0d a=%h got %h want %h", n, f3, a, o_rd, exp_rd); else pass_cnt++;
            total++; if (sc !== d + 1) $display("FAIL rnd_stall_cycles n=%0d got %0d want %0d", n, sc, d + 1); else pass_cnt++;
            total++; if (mc !== d) $display("FAIL rnd_mreq_cycles n=%0d got %0d want %0d", n, mc, d); else pass_cnt++;
            total++; if (o_dstall !== 1'b0) $display("FAIL rnd_done_stall n=%0d got %0b want 0", n, o_dstall); else pass_cnt++;
            total++; if (o_unst !== 1'b0) $display("FAIL rnd_mwe_stable n=%0d got %0b want 0", n, o_unst); else pass_cnt++;
        end
        mack = 1'b0;
    endtask

`ifdef LSU_MISALIGN_TRAP_EN
    task automatic test_misalign();
        memread = 1'b1;
        memwrite = 1'b0;
        funct3 = 3'b010;
        addr = 32'h101;
        mack = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (c == 2) memread = 1'b0;
            @(negedge clk);
            total++; if (mreq !== 1'b0) $display("FAIL mis_mreq cyc %0d got %0b want 0", c, mreq); else pass_cnt++;
            total++; if (stall !== (c == 0)) $display("FAIL mis_stall cyc %0d got %0b want %0b", c, stall, (c == 0)); else pass_cnt++;
            total++; if (misalign !== (c == 1)) $display("FAIL mis_pulse cyc %0d got %0b want %0b", c, misalign, (c == 1)); else pass_cnt++;
            total++; if (readdata !== exp_rd) $display("FAIL mis_readdata cyc %0d got %h want %h", c, readdata, exp_rd); else pass_cnt++;
            @(posedge clk);
            #1;
        end
    endtask
`endif

    initial begin
        exp_rd = 32'b0;
        test_reset();
        test_lw();
        test_lb_lbu();
        test_sh();
        test_reset_mid();
        test_back_to_back();
        test_random();
`ifdef LSU_MISALIGN_TRAP_EN
        test_misalign();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
